// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
// Instruction layout, FSM states and default sizing live here.
package alu_seq_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int NREGS_DEF  = 4;
   localparam int INSTR_W    = 20;
   localparam int REG_AW     = 2;
   localparam int OPC_W      = 4;

   localparam int OPC_MSB    = 19;
   localparam int OPC_LSB    = 16;
   localparam int DST_MSB    = 15;
   localparam int DST_LSB    = 14;
   localparam int SRCA_MSB   = 13;
   localparam int SRCA_LSB   = 12;
   localparam int SRCB_MSB   = 11;
   localparam int SRCB_LSB   = 10;
   localparam int IMMSEL_BIT = 9;
   localparam int LOAD_BIT   = 8;
   localparam int IMM_MSB    = 7;
   localparam int IMM_LSB    = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2
   } seq_state_e;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [REG_AW-1:0] dst;
      logic [REG_AW-1:0] src_a;
      logic [REG_AW-1:0] src_b;
      logic              imm_sel;
      logic              load;
      logic [7:0]        imm;
   } instr_t;

   function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
      instr_t d;
      d.opcode  = raw[OPC_MSB:OPC_LSB];
      d.dst     = raw[DST_MSB:DST_LSB];
      d.src_a   = raw[SRCA_MSB:SRCA_LSB];
      d.src_b   = raw[SRCB_MSB:SRCB_LSB];
      d.imm_sel = raw[IMMSEL_BIT];
      d.load    = raw[LOAD_BIT];
      d.imm     = raw[IMM_MSB:IMM_LSB];
      return d;
   endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Small register file: one write port, three combinational read ports.
// Contents clear asynchronously on reset.
import alu_seq_pkg::*;

module alu_seq_regfile #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] ra_addr_i,
   output logic [DATA_W-1:0] ra_data_o,
   input  logic [REG_AW-1:0] rb_addr_i,
   output logic [DATA_W-1:0] rb_data_o,
   input  logic [REG_AW-1:0] rc_addr_i,
   output logic [DATA_W-1:0] rc_data_o
);

   logic [DATA_W-1:0] regs_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign ra_data_o = regs_q[ra_addr_i];
   assign rb_data_o = regs_q[rb_addr_i];
   assign rc_data_o = regs_q[rc_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Issues register-file instructions to an external clocked ALU and
// writes results back; loads bypass the ALU and complete in one cycle.
import alu_seq_pkg::*;

module alu_sequencer #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [OPC_W-1:0]   alu_opcode,
   input  logic [DATA_W-1:0]  alu_op,
   input  logic               alu_carry,
   input  logic               alu_zero,
   output logic               res_valid,
   output logic [DATA_W-1:0]  res_data,
   output logic [REG_AW-1:0]  res_dst,
   output logic               flag_carry,
   output logic               flag_zero,
   input  logic [REG_AW-1:0]  rd_addr,
   output logic [DATA_W-1:0]  rd_data
);

   instr_t            ins;
   seq_state_e        state_q, state_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [OPC_W-1:0]  opc_q, opc_d;
   logic [REG_AW-1:0] dst_q, dst_d;
   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic [REG_AW-1:0] res_dst_q, res_dst_d;
   logic              carry_q, carry_d;
   logic              zero_q, zero_d;

   logic              accept;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] src_a_val;
   logic [DATA_W-1:0] src_b_val;
   logic [DATA_W-1:0] imm_ext;

   assign ins     = decode(instr);
   assign imm_ext = DATA_W'(ins.imm);

   // Ready depends on state only, never on instr_valid.
   assign instr_ready = (state_q == IDLE);
   assign accept      = instr_valid && instr_ready;

   alu_seq_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (rf_we),
      .waddr_i   (rf_waddr),
      .wdata_i   (rf_wdata),
      .ra_addr_i (ins.src_a),
      .ra_data_o (src_a_val),
      .rb_addr_i (ins.src_b),
      .rb_data_o (src_b_val),
      .rc_addr_i (rd_addr),
      .rc_data_o (rd_data)
   );

   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      opc_d       = opc_q;
      dst_d       = dst_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_dst_d   = res_dst_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      rf_we       = 1'b0;
      rf_waddr    = ins.dst;
      rf_wdata    = imm_ext;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (ins.load) begin
                  rf_we = 1'b1;
               end else begin
                  alu_a_d = src_a_val;
                  alu_b_d = ins.imm_sel ? imm_ext : src_b_val;
                  opc_d   = ins.opcode;
                  dst_d   = ins.dst;
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            state_d = CAPT;
         end
         CAPT: begin
            rf_we    = 1'b1;
            rf_waddr = dst_q;
            rf_wdata = alu_op;
            carry_d  = alu_carry;
            zero_d   = alu_zero;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Every register-file write is reported one cycle later.
      if (rf_we) begin
         res_valid_d = 1'b1;
         res_data_d  = rf_wdata;
         res_dst_d   = rf_waddr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         opc_q       <= '0;
         dst_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_dst_q   <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         opc_q       <= opc_d;
         dst_q       <= dst_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_dst_q   <= res_dst_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = opc_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_dst    = res_dst_q;
   assign flag_carry = carry_q;
   assign flag_zero  = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a 1-cycle bench ALU.
// Stimulus pushes expected results; a negedge monitor pops and checks.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [19:0] instr;
   logic [7:0]  alu_a, alu_b;
   logic [3:0]  alu_opcode;
   logic [7:0]  alu_op;
   logic        alu_carry, alu_zero;
   logic        res_valid;
   logic [7:0]  res_data;
   logic [1:0]  res_dst;
   logic        flag_carry, flag_zero;
   logic [1:0]  rd_addr;
   logic [7:0]  rd_data;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] dst;
      logic       c;
      logic       z;
   } exp_t;

   exp_t sbq[$];
   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   int   pulses   = 0;
   logic tc = 1'b0;
   logic tz = 1'b0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_opcode  (alu_opcode),
      .alu_op      (alu_op),
      .alu_carry   (alu_carry),
      .alu_zero    (alu_zero),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_dst     (res_dst),
      .flag_carry  (flag_carry),
      .flag_zero   (flag_zero),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data)
   );

   // Bench ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, else a + opcode.
   function automatic logic [8:0] alu_ref(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [3:0] op);
      logic [8:0] s;
      case (op)
         4'h0:    s = {1'b0, a} + {1'b0, b};
         4'h1:    s = {1'b0, a} - {1'b0, b};
         4'h2:    s = {1'b0, a & b};
         4'h3:    s = {1'b0, a | b};
         4'h4:    s = {1'b0, a ^ b};
         default: s = {1'b0, a + {4'h0, op}};
      endcase
      return s;
   endfunction

   always @(posedge clk) begin
      logic [8:0] s;
      s = alu_ref(alu_a, alu_b, alu_opcode);
      alu_op    <= s[7:0];
      alu_carry <= s[8];
      alu_zero  <= (s[7:0] == 8'h00);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (res_valid) begin
         pulses++;
         if (sbq.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_res_valid: data 0x%0h dst %0d",
                     res_data, res_dst);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("res_data", {24'h0, res_data}, {24'h0, e.data});
            chk("res_dst", {30'h0, res_dst}, {30'h0, e.dst});
            chk("flag_carry", {31'h0, flag_carry}, {31'h0, e.c});
            chk("flag_zero", {31'h0, flag_zero}, {31'h0, e.z});
         end
      end
   end

   function automatic logic [19:0] mk(input logic [3:0] op,
                                      input logic [1:0] dst,
                                      input logic [1:0] sa,
                                      input logic [1:0] sb,
                                      input logic isel, input logic ld,
                                      input logic [7:0] imm);
      return {op, dst, sa, sb, isel, ld, imm};
   endfunction

   task automatic send(input logic [19:0] ins, output int waited,
                       output logic rv_seen);
      instr       = ins;
      instr_valid = 1'b1;
      waited      = 0;
      while (!instr_ready && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (!instr_ready) begin
         chk_cnt++;
         $display("FAIL accept_timeout: ready 0 after %0d cycles", waited);
      end
      rv_seen = res_valid;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic do_load(input logic [1:0] dst, input logic [7:0] imm);
      int   w;
      logic rv;
      sbq.push_back('{data: imm, dst: dst, c: tc, z: tz});
      send(mk(4'h0, dst, 2'd0, 2'd0, 1'b0, 1'b1, imm), w, rv);
   endtask

   task automatic do_alu(input logic [19:0] ins, input logic [7:0] d,
                         input logic c, input logic z,
                         output int w, output logic rv);
      tc = c;
      tz = z;
      sbq.push_back('{data: d, dst: ins[15:14], c: c, z: z});
      send(ins, w, rv);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!instr_ready && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!instr_ready) begin
         chk_cnt++;
         $display("FAIL idle_timeout: ready 0 after %0d cycles", n);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int         w, w2, p0;
      logic       rv, rv2;
      logic [8:0] s;

      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      rd_addr     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'h0, instr_ready}, 32'h1);
      chk("rst_alu_a", {24'h0, alu_a}, 32'h0);
      chk("rst_alu_opcode", {28'h0, alu_opcode}, 32'h0);
      chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
      chk("rst_flags", {30'h0, flag_carry, flag_zero}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_load(2'd0, 8'h0A);
      do_load(2'd1, 8'h02);
      rd_addr = 2'd0;
      #1;
      chk("rd_r0_after_load", {24'h0, rd_data}, 32'h0A);

      do_alu(mk(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 8'h00),
             8'h0C, 1'b0, 1'b0, w, rv);
      chk("exec_alu_a", {24'h0, alu_a}, 32'h0A);
      chk("exec_alu_b", {24'h0, alu_b}, 32'h02);
      chk("exec_ready_low", {31'h0, instr_ready}, 32'h0);
      wait_idle();

      do_load(2'd0, 8'hF6);
      do_alu(mk(4'h0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 8'h0A),
             8'h00, 1'b1, 1'b1, w, rv);
      chk("imm_alu_b", {24'h0, alu_b}, 32'h0A);
      wait_idle();
      @(posedge clk);
      #1;
      rd_addr = 2'd3;
      #1;
      chk("rd_r3_wrap", {24'h0, rd_data}, 32'h00);

      do_alu(mk(4'h0, 2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 8'h00),
             8'h04, 1'b0, 1'b0, w, rv);
      do_alu(mk(4'h0, 2'd1, 2'd2, 2'd2, 1'b0, 1'b0, 8'h00),
             8'h08, 1'b0, 1'b0, w2, rv2);
      chk("held_wait_cycles", w2, 32'd2);
      chk("held_accept_with_res", {31'h0, rv2}, 32'h1);
      wait_idle();
      @(posedge clk);
      #1;

      p0 = pulses;
      for (int op = 0; op < 16; op++) begin
         s = alu_ref(8'h08, 8'h04, 4'(op));
         do_alu(mk(4'(op), 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 8'h00),
                s[7:0], s[8], (s[7:0] == 8'h00), w, rv);
         chk("sweep_opcode", {28'h0, alu_opcode}, op);
         wait_idle();
      end
      repeat (2) @(posedge clk);
      #1;
      chk("sweep_pulses", pulses - p0, 32'd16);

      do_load(2'd0, 8'hFF);
      do_alu(mk(4'h0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00),
             8'hFE, 1'b1, 1'b0, w, rv);
      wait_idle();
      @(posedge clk);
      #1;
      chk("carry_before_rst", {31'h0, flag_carry}, 32'h1);

      p0 = pulses;
      send(mk(4'h0, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00), w, rv);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {31'h0, instr_ready}, 32'h1);
      chk("mid_rst_res_valid", {31'h0, res_valid}, 32'h0);
      chk("mid_rst_flags", {30'h0, flag_carry, flag_zero}, 32'h0);
      chk("mid_rst_alu_a", {24'h0, alu_a}, 32'h0);
      chk("mid_rst_res_data", {24'h0, res_data}, 32'h0);
      for (int r = 0; r < 4; r++) begin
         rd_addr = 2'(r);
         #1;
         chk("mid_rst_reg", {24'h0, rd_data}, 32'h0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_rst_no_pulse", pulses - p0, 32'd0);
      chk("scoreboard_empty", sbq.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
